// File: rtl/object_draw_scanner.sv
// object_draw_scanner: per-frame shadow of the object table, a 2-stage per-pixel
// hit pipeline (lowest index wins) and per-frame player-vs-object overlap reporting.

// Per-object hit test and sprite-local offsets. This block is purely combinational.
module object_draw_scanner_lane #(
  parameter int W = 11
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] width,
  input  logic [W-1:0] height,
  input  logic [W-1:0] pixel_x,
  input  logic [W-1:0] pixel_y,
  output logic         hit,
  output logic [W-1:0] off_x,
  output logic [W-1:0] off_y
);
  // The end coordinates use one extra bit, so a sprite near the right or bottom edge does not wrap.
  logic [W:0] x_end, y_end;
  logic       in_x, in_y;

  assign x_end = {1'b0, x} + {1'b0, width};
  assign y_end = {1'b0, y} + {1'b0, height};
  assign in_x  = (pixel_x >= x) && ({1'b0, pixel_x} < x_end);
  assign in_y  = (pixel_y >= y) && ({1'b0, pixel_y} < y_end);
  assign hit   = (width != '0) && (height != '0) && in_x && in_y;
  assign off_x = pixel_x - x;
  assign off_y = pixel_y - y;
endmodule

module object_draw_scanner #(
  parameter int NUM_OBJ = 3,
  parameter int W       = 11
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic                            frame_start,
  input  logic [0:NUM_OBJ-1][0:4][0:W-1]  object_table,
  input  logic                            pixel_valid,
  input  logic [W-1:0]                    pixelX,
  input  logic [W-1:0]                    pixelY,
  output logic                            drawing_request,
  output logic [$clog2(NUM_OBJ)-1:0]      hit_index,
  output logic [W-1:0]                    img_id,
  output logic [W-1:0]                    offset_x,
  output logic [W-1:0]                    offset_y,
  output logic                            collision,
  output logic [$clog2(NUM_OBJ)-1:0]      collision_index
);
  localparam int IW = $clog2(NUM_OBJ);

  logic [0:NUM_OBJ-1][0:4][0:W-1] shadow;

  logic [NUM_OBJ-1:0]          lane_hit;
  logic [NUM_OBJ-1:0][W-1:0]   lane_ox, lane_oy;

  logic                        valid_s1;
  logic [NUM_OBJ-1:0]          hit_s1;
  logic [NUM_OBJ-1:0][W-1:0]   ox_s1, oy_s1;

  logic                        win_hit;
  logic [IW-1:0]               win_idx;
  logic                        ov_any;
  logic [IW-1:0]               ov_idx;
  logic                        ov;
  logic                        sticky;

  // Latch the whole table at frame start; the table stays frozen for the rest of the frame.
  always_ff @(posedge clk or negedge resetN)
    if (!resetN)          shadow <= '0;
    else if (frame_start) shadow <= object_table;

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_lane
    object_draw_scanner_lane #(.W(W)) u_lane (
      .x       (shadow[g][1]),
      .y       (shadow[g][2]),
      .width   (shadow[g][3]),
      .height  (shadow[g][4]),
      .pixel_x (pixelX),
      .pixel_y (pixelY),
      .hit     (lane_hit[g]),
      .off_x   (lane_ox[g]),
      .off_y   (lane_oy[g])
    );
  end

  // Stage 1: register the valid bit, the per-object hits and the per-object offsets.
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      valid_s1 <= 1'b0;
      hit_s1   <= '0;
      ox_s1    <= '0;
      oy_s1    <= '0;
    end else begin
      valid_s1 <= pixel_valid;
      hit_s1   <= lane_hit;
      ox_s1    <= lane_ox;
      oy_s1    <= lane_oy;
    end

  // Lowest-index priority encode, for drawing and for the overlapping non-player object.
  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    ov_any  = 1'b0;
    ov_idx  = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--)
      if (hit_s1[i]) begin
        win_hit = 1'b1;
        win_idx = IW'(i);
      end
    for (int i = NUM_OBJ - 1; i >= 1; i--)
      if (hit_s1[i]) begin
        ov_any = 1'b1;
        ov_idx = IW'(i);
      end
    ov = valid_s1 && hit_s1[0] && ov_any;
  end

  // Stage 2: registered draw outputs. All fields are zero when nothing is drawn.
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      drawing_request <= 1'b0;
      hit_index       <= '0;
      img_id          <= '0;
      offset_x        <= '0;
      offset_y        <= '0;
    end else if (valid_s1 && win_hit) begin
      drawing_request <= 1'b1;
      hit_index       <= win_idx;
      img_id          <= shadow[win_idx][0];
      offset_x        <= ox_s1[win_idx];
      offset_y        <= oy_s1[win_idx];
    end else begin
      drawing_request <= 1'b0;
      hit_index       <= '0;
      img_id          <= '0;
      offset_x        <= '0;
      offset_y        <= '0;
    end

  // Overlap accumulation. An overlap seen on the frame_start cycle counts toward the ending frame.
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      sticky          <= 1'b0;
      collision       <= 1'b0;
      collision_index <= '0;
    end else begin
      if (ov && !sticky) collision_index <= ov_idx;
      if (frame_start) begin
        collision <= sticky || ov;
        sticky    <= 1'b0;
      end else begin
        collision <= 1'b0;
        if (ov) sticky <= 1'b1;
      end
    end
endmodule

// File: tb/tb_object_draw_scanner.sv
// Bench for object_draw_scanner: directed test-plan steps followed by random frames.
// A reference model compares each output 2 cycles after the pixel is presented.
module tb_object_draw_scanner;
  localparam int NUM_OBJ = 3;
  localparam int W       = 11;
  localparam int IW      = $clog2(NUM_OBJ);

  logic                           clk = 1'b0;
  logic                           resetN;
  logic                           frame_start;
  logic [0:NUM_OBJ-1][0:4][0:W-1] object_table;
  logic                           pixel_valid;
  logic [W-1:0]                   pixelX, pixelY;
  logic                           drawing_request;
  logic [IW-1:0]                  hit_index;
  logic [W-1:0]                   img_id, offset_x, offset_y;
  logic                           collision;
  logic [IW-1:0]                  collision_index;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int sh[NUM_OBJ][5];          // latched table
  bit p_v;                     // pixel presented in the previous cycle
  bit [NUM_OBJ-1:0] p_hit;
  int p_ox[NUM_OBJ], p_oy[NUM_OBJ];
  int first_k;                 // first overlapping object this frame, -1 if none
  int cidx_m;                  // model collision_index

  object_draw_scanner #(.NUM_OBJ(NUM_OBJ), .W(W)) dut (
    .clk(clk), .resetN(resetN), .frame_start(frame_start), .object_table(object_table),
    .pixel_valid(pixel_valid), .pixelX(pixelX), .pixelY(pixelY),
    .drawing_request(drawing_request), .hit_index(hit_index), .img_id(img_id),
    .offset_x(offset_x), .offset_y(offset_y), .collision(collision),
    .collision_index(collision_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_obj(input int i, input int img, input int x, input int y, input int w, input int h);
    object_table[i][0] = W'(img);
    object_table[i][1] = W'(x);
    object_table[i][2] = W'(y);
    object_table[i][3] = W'(w);
    object_table[i][4] = W'(h);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_OBJ; i++) for (int f = 0; f < 5; f++) sh[i][f] = 0;
    p_v = 0; p_hit = '0; first_k = -1; cidx_m = 0;
    for (int i = 0; i < NUM_OBJ; i++) begin p_ox[i] = 0; p_oy[i] = 0; end
  endtask

  // Present one cycle of input, advance the clock, and check the outputs for the previous pixel.
  task automatic step(input bit pv, input int px, input int py, input bit fs);
    bit [NUM_OBJ-1:0] c_hit;
    int c_ox[NUM_OBJ], c_oy[NUM_OBJ];
    int e_dr, e_idx, e_img, e_ox, e_oy, e_col, ovk;
    pixel_valid = pv; pixelX = W'(px); pixelY = W'(py); frame_start = fs;
    // Evaluate the new pixel against the table as it was before this edge.
    for (int i = 0; i < NUM_OBJ; i++) begin
      c_hit[i] = sh[i][3] != 0 && sh[i][4] != 0 &&
                 px >= sh[i][1] && px < sh[i][1] + sh[i][3] &&
                 py >= sh[i][2] && py < sh[i][2] + sh[i][4];
      c_ox[i] = (px - sh[i][1]) & 2047;
      c_oy[i] = (py - sh[i][2]) & 2047;
    end
    // Resolve the previous pixel: the lowest-index hit wins.
    e_dr = 0; e_idx = 0; e_img = 0; e_ox = 0; e_oy = 0;
    if (p_v) begin
      for (int i = 0; i < NUM_OBJ; i++)
        if (p_hit[i] && !e_dr) begin
          e_dr = 1; e_idx = i; e_img = sh[i][0]; e_ox = p_ox[i]; e_oy = p_oy[i];
        end
    end
    ovk = -1;
    if (p_v && p_hit[0])
      for (int k = 1; k < NUM_OBJ; k++) if (p_hit[k] && ovk < 0) ovk = k;
    if (ovk >= 0 && first_k < 0) begin first_k = ovk; cidx_m = ovk; end
    e_col = (fs && first_k >= 0) ? 1 : 0;
    if (fs) begin
      first_k = -1;
      for (int i = 0; i < NUM_OBJ; i++) for (int f = 0; f < 5; f++) sh[i][f] = int'(object_table[i][f]);
    end
    @(posedge clk); #1;
    chk("drawing_request", 32'(drawing_request), 32'(e_dr));
    chk("hit_index",       32'(hit_index),       32'(e_idx));
    chk("img_id",          32'(img_id),          32'(e_img));
    chk("offset_x",        32'(offset_x),        32'(e_ox));
    chk("offset_y",        32'(offset_y),        32'(e_oy));
    chk("collision",       32'(collision),       32'(e_col));
    chk("collision_index", 32'(collision_index), 32'(cidx_m));
    p_v = pv; p_hit = c_hit;
    for (int i = 0; i < NUM_OBJ; i++) begin p_ox[i] = c_ox[i]; p_oy[i] = c_oy[i]; end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dr"},   32'(drawing_request), 0);
    chk({tag, "_idx"},  32'(hit_index),       0);
    chk({tag, "_img"},  32'(img_id),          0);
    chk({tag, "_ox"},   32'(offset_x),        0);
    chk({tag, "_oy"},   32'(offset_y),        0);
    chk({tag, "_col"},  32'(collision),       0);
    chk({tag, "_cidx"}, 32'(collision_index), 0);
  endtask

  initial begin
    resetN = 1'b0; frame_start = 0; pixel_valid = 0; pixelX = '0; pixelY = '0;
    object_table = '0;
    model_clear();
    #1 chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    chk_zero("reset_hold");

    // Single player sprite: corner hits and edge misses
    set_obj(0, 0, 256, 380, 32, 36);
    step(0, 0, 0, 1);
    step(1, 256, 380, 0); step(0, 0, 0, 0);
    chk("tp_corner_dr", 32'(drawing_request), 1);
    chk("tp_corner_ox", 32'(offset_x), 0);
    step(1, 287, 415, 0); step(0, 0, 0, 0);
    chk("tp_far_ox", 32'(offset_x), 31);
    chk("tp_far_oy", 32'(offset_y), 35);
    step(1, 288, 380, 0); step(0, 0, 0, 0);
    chk("tp_xedge_dr", 32'(drawing_request), 0);
    step(1, 256, 416, 0); step(0, 0, 0, 0);
    chk("tp_yedge_dr", 32'(drawing_request), 0);

    // Overlap priority and collision report
    set_obj(1, 99, 270, 390, 16, 16);
    step(0, 0, 0, 1);
    step(1, 275, 395, 0); step(0, 0, 0, 0);
    chk("tp_prio_idx", 32'(hit_index), 0);
    step(0, 0, 0, 1);
    chk("tp_coll", 32'(collision), 1);
    chk("tp_coll_idx", 32'(collision_index), 1);
    step(0, 0, 0, 0);
    chk("tp_coll_pulse", 32'(collision), 0);
    step(1, 10, 10, 0); step(0, 0, 0, 1);
    chk("tp_no_coll", 32'(collision), 0);
    step(0, 0, 0, 1);   // back-to-back frame_start

    // Shadow isolation
    object_table[0][1] = W'(300);
    step(1, 256, 380, 0); step(0, 0, 0, 0);
    chk("tp_shadow_old", 32'(drawing_request), 1);
    step(0, 0, 0, 1);
    step(1, 256, 380, 0); step(1, 300, 380, 0);
    chk("tp_shadow_miss", 32'(drawing_request), 0);
    step(0, 0, 0, 0);
    chk("tp_shadow_new", 32'(drawing_request), 1);

    // Disabled record and right-edge overflow
    object_table[1][3] = W'(0);
    set_obj(2, 5, 2040, 10, 20, 4);
    step(0, 0, 0, 1);
    step(1, 275, 395, 0); step(1, 2047, 11, 0);
    chk("tp_disabled", 32'(drawing_request), 0);
    step(1, 3, 11, 0);
    chk("tp_ovf_ox", 32'(offset_x), 7);
    chk("tp_ovf_idx", 32'(hit_index), 2);
    step(0, 0, 0, 0);
    chk("tp_nowrap", 32'(drawing_request), 0);

    // 40-pixel stream with toggling valid
    set_obj(1, 77, 260, 380, 20, 20);
    object_table[0][1] = W'(256);
    step(0, 0, 0, 1);
    for (int n = 0; n < 40; n++)
      step(n[0] == 1'b0, 250 + (n % 40), 378 + (n % 7) * 3, 0);

    // Random frames; frame_start can arrive while pixels are still in flight
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < NUM_OBJ; i++)
        if ($urandom_range(0, 9) == 0)
          set_obj(i, $urandom_range(0, 2047), $urandom_range(2030, 2047), $urandom_range(0, 60),
                  $urandom_range(0, 30), $urandom_range(0, 30));
        else
          set_obj(i, $urandom_range(0, 2047), $urandom_range(0, 60), $urandom_range(0, 60),
                  $urandom_range(0, 30), $urandom_range(0, 30));
      step($urandom_range(0, 1), $urandom_range(0, 95), $urandom_range(0, 95), 1);
      for (int n = 0; n < 60; n++) begin
        if ($urandom_range(0, 15) == 0)
          step($urandom_range(0, 1), $urandom_range(2030, 2047), $urandom_range(0, 95), 0);
        else
          step($urandom_range(0, 3) != 0, $urandom_range(0, 95), $urandom_range(0, 95), 0);
        if ($urandom_range(0, 9) == 0) object_table[$urandom_range(0, NUM_OBJ - 1)][1] = W'($urandom_range(0, 60));
      end
    end

    // Mid-frame reset, with an overlap recorded and pixels in flight
    set_obj(0, 1, 100, 100, 10, 10);
    set_obj(1, 2, 100, 100, 10, 10);
    set_obj(2, 3, 0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(1, 101, 101, 0); step(1, 102, 102, 0); step(1, 103, 103, 0);
    #2 resetN = 1'b0;
    #1 chk_zero("async_reset");
    model_clear();
    @(posedge clk); #1;
    chk_zero("reset_mid");
    resetN = 1'b1;
    pixel_valid = 0;
    step(0, 0, 0, 1);
    chk("reset_lost_coll", 32'(collision), 0);
    step(1, 101, 101, 0); step(0, 0, 0, 0);
    chk("reset_relatch", 32'(drawing_request), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
